// File: rtl/pkt_bufid_alloc.sv
// Packet buffer ID allocator: a circular free list of buffer IDs. After reset the
// list is filled with IDs 0..BUFID_NUM-1. One ID at a time is offered to the consumer
// until it is acknowledged. Returned IDs are appended at the tail.
// Optional feature macro: BUFID_OVERFLOW_CHK_EN (pulse o_free_overflow on a dropped return).
module pkt_bufid_alloc #(
  parameter int unsigned BUFID_NUM = 512
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_pkt_bufid_wr,
  output logic [8:0] ov_pkt_bufid,
  input  logic       i_pkt_bufid_ack,
  input  logic       i_bufid_free_wr,
  input  logic [8:0] iv_bufid_free,
  output logic [9:0] ov_free_bufid_cnt,
  output logic       o_pool_empty,
  output logic       o_free_overflow,
  output logic [1:0] ov_alloc_state
);

  localparam int unsigned AW = (BUFID_NUM > 1) ? $clog2(BUFID_NUM) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(BUFID_NUM - 1);
  localparam logic [9:0] FullCnt = 10'(BUFID_NUM);

  typedef enum logic [1:0] {
    StInit  = 2'b00,
    StIdle  = 2'b01,
    StOffer = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    mem_q [BUFID_NUM];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [8:0]    bufid_q, bufid_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [8:0]    mem_wdata;
  logic          pop, push;
`ifdef BUFID_OVERFLOW_CHK_EN
  logic          ovf_q, ovf_d;
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // Next-state: init fill, offer handshake, and free-list push/pop bookkeeping.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    bufid_d    = bufid_q;
    mem_we     = 1'b0;
    mem_waddr  = init_cnt_q;
    mem_wdata  = 9'(init_cnt_q);
    pop        = 1'b0;
    push       = 1'b0;
`ifdef BUFID_OVERFLOW_CHK_EN
    ovf_d      = 1'b0;
`endif

    unique case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        init_cnt_d = ptr_inc(init_cnt_q);
        if (init_cnt_q == LastIdx) begin
          cnt_d   = FullCnt;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          wr_d    = 1'b1;
          bufid_d = mem_q[rd_ptr_q];
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (i_pkt_bufid_ack) begin
          wr_d    = 1'b0;
          bufid_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    // A full list still accepts a return when the head is popped on the same edge.
    if (state_q != StInit && i_bufid_free_wr) begin
      if (cnt_q != FullCnt || pop) begin
        push = 1'b1;
      end
`ifdef BUFID_OVERFLOW_CHK_EN
      else begin
        ovf_d = 1'b1;
      end
`endif
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      mem_we    = 1'b1;
      mem_waddr = wr_ptr_q;
      mem_wdata = iv_bufid_free;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end
    if (pop && !push) begin
      cnt_d = cnt_q - 10'd1;
    end else if (push && !pop) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // Free-list storage; contents are rebuilt by the init sweep, so no reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StInit;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      bufid_q    <= '0;
`ifdef BUFID_OVERFLOW_CHK_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      bufid_q    <= bufid_d;
`ifdef BUFID_OVERFLOW_CHK_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign o_pkt_bufid_wr    = wr_q;
  assign ov_pkt_bufid      = bufid_q;
  assign ov_free_bufid_cnt = cnt_q;
  assign o_pool_empty      = (cnt_q == '0);
  assign ov_alloc_state    = state_q;
`ifdef BUFID_OVERFLOW_CHK_EN
  assign o_free_overflow   = ovf_q;
`else
  assign o_free_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_bufid_alloc.sv
// Bench for pkt_bufid_alloc: a 4-entry instance tracked every cycle by a free-list
// scoreboard, and a 512-entry instance for init length, offer order and mid-offer reset.
module tb_pkt_bufid_alloc;

  localparam int unsigned NA = 4;

  logic       clk, rst;
  logic       a_ack, a_free_wr, b_ack, b_free_wr;
  logic [8:0] a_free, b_free;
  logic       a_wr, a_empty, a_ovf, b_wr, b_empty, b_ovf;
  logic [8:0] a_id, b_id;
  logic [9:0] a_cnt, b_cnt;
  logic [1:0] a_st, b_st;

  int checks = 0;
  int errors = 0;

  // Scoreboard for the small instance: expected free list, in pop order.
  logic [8:0] qa[$];
  int         a_init_left;
  logic       a_off;
  logic [8:0] a_cur;

  pkt_bufid_alloc #(.BUFID_NUM(NA)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .o_pkt_bufid_wr(a_wr), .ov_pkt_bufid(a_id), .i_pkt_bufid_ack(a_ack),
    .i_bufid_free_wr(a_free_wr), .iv_bufid_free(a_free),
    .ov_free_bufid_cnt(a_cnt), .o_pool_empty(a_empty), .o_free_overflow(a_ovf),
    .ov_alloc_state(a_st)
  );

  pkt_bufid_alloc #(.BUFID_NUM(512)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .o_pkt_bufid_wr(b_wr), .ov_pkt_bufid(b_id), .i_pkt_bufid_ack(b_ack),
    .i_bufid_free_wr(b_free_wr), .iv_bufid_free(b_free),
    .ov_free_bufid_cnt(b_cnt), .o_pool_empty(b_empty), .o_free_overflow(b_ovf),
    .ov_alloc_state(b_st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of the small instance: update the scoreboard, clock, then compare.
  task automatic step_a(input logic ack, input logic fwr, input logic [8:0] fid);
    logic       ovf_exp;
    logic [1:0] st_exp;
    logic [8:0] id_exp;
    ovf_exp   = 1'b0;
    a_ack     = ack;
    a_free_wr = fwr;
    a_free    = fid;
    if (rst) begin
      qa.delete();
      a_off       = 1'b0;
      a_init_left = NA;
    end else if (a_init_left != 0) begin
      a_init_left--;
      if (a_init_left == 0) begin
        for (int k = 0; k < NA; k++) qa.push_back(9'(k));
      end
    end else begin
      if (a_off) begin
        if (ack) a_off = 1'b0;
      end else if (qa.size() > 0) begin
        a_cur = qa.pop_front();
        a_off = 1'b1;
      end
      if (fwr) begin
        if (qa.size() < NA) qa.push_back(fid);
        else ovf_exp = 1'b1;
      end
    end
    tick();
    a_ack     = 1'b0;
    a_free_wr = 1'b0;
`ifndef BUFID_OVERFLOW_CHK_EN
    ovf_exp = 1'b0;
`endif
    st_exp = (a_init_left != 0) ? 2'b00 : (a_off ? 2'b10 : 2'b01);
    id_exp = a_off ? a_cur : 9'd0;
    checks++;
    if (a_wr !== a_off) begin
      errors++; $display("FAIL a_wr got %0b exp %0b t=%0t", a_wr, a_off, $time);
    end
    checks++;
    if (a_id !== id_exp) begin
      errors++; $display("FAIL a_id got %0d exp %0d t=%0t", a_id, id_exp, $time);
    end
    checks++;
    if (a_cnt !== 10'(qa.size())) begin
      errors++; $display("FAIL a_cnt got %0d exp %0d t=%0t", a_cnt, qa.size(), $time);
    end
    checks++;
    if (a_empty !== (qa.size() == 0)) begin
      errors++; $display("FAIL a_empty got %0b exp %0b t=%0t", a_empty, qa.size() == 0, $time);
    end
    checks++;
    if (a_st !== st_exp) begin
      errors++; $display("FAIL a_state got %0d exp %0d t=%0t", a_st, st_exp, $time);
    end
    checks++;
    if (a_ovf !== ovf_exp) begin
      errors++; $display("FAIL a_ovf got %0b exp %0b t=%0t", a_ovf, ovf_exp, $time);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_a(0, 0, 0);
    step_a(0, 0, 0);
    checks++;
    if (b_wr !== 1'b0 || b_id !== 9'd0) begin
      errors++; $display("FAIL rst_b_offer got wr=%0b id=%0d exp 0/0", b_wr, b_id);
    end
    checks++;
    if (b_cnt !== 10'd0 || b_empty !== 1'b1) begin
      errors++; $display("FAIL rst_b_cnt got cnt=%0d empty=%0b exp 0/1", b_cnt, b_empty);
    end
    checks++;
    if (b_st !== 2'b00 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_b_state got st=%0d ovf=%0b exp 0/0", b_st, b_ovf);
    end
  endtask

  // Count cycles of wr=0 on the large instance after reset release.
  task automatic wait_b_init(input string name);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    rst   = 1'b0;
    for (int k = 0; k < 600; k++) begin
      step_a(0, 0, 0);
      if (b_wr) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    checks++;
    if (!found || n != 512) begin
      errors++; $display("FAIL %s_len got found=%0b idle=%0d exp 1/512", name, found, n);
    end
    checks++;
    if (b_id !== 9'd0 || b_cnt !== 10'd511 || b_st !== 2'b10) begin
      errors++;
      $display("FAIL %s_first got id=%0d cnt=%0d st=%0d exp 0/511/2", name, b_id, b_cnt, b_st);
    end
  endtask

  task automatic test_init();
    wait_b_init("init");
  endtask

  task automatic test_offer_order();
    for (int i = 0; i < 2; i++) begin
      b_ack = 1'b1;
      step_a(0, 0, 0);
      b_ack = 1'b0;
      checks++;
      if (b_wr !== 1'b0 || b_id !== 9'd0) begin
        errors++; $display("FAIL order_gap got wr=%0b id=%0d exp 0/0", b_wr, b_id);
      end
      step_a(0, 0, 0);
      checks++;
      if (b_wr !== 1'b1 || b_id !== 9'(i + 1) || b_cnt !== 10'(510 - i)) begin
        errors++;
        $display("FAIL order_id got wr=%0b id=%0d cnt=%0d exp 1/%0d/%0d",
                 b_wr, b_id, b_cnt, i + 1, 510 - i);
      end
    end
  endtask

  task automatic test_drain_empty();
    for (int i = 0; i < 4; i++) begin
      step_a(1, 0, 0);
      step_a(0, 0, 0);
    end
    step_a(0, 0, 0);
    checks++;
    if (a_empty !== 1'b1 || a_wr !== 1'b0) begin
      errors++; $display("FAIL drain_empty got empty=%0b wr=%0b exp 1/0", a_empty, a_wr);
    end
    step_a(0, 1, 9'd2);
    checks++;
    if (a_wr !== 1'b0 || a_cnt !== 10'd1) begin
      errors++; $display("FAIL drain_push got wr=%0b cnt=%0d exp 0/1", a_wr, a_cnt);
    end
    step_a(0, 0, 0);
    checks++;
    if (a_wr !== 1'b1 || a_id !== 9'd2) begin
      errors++; $display("FAIL drain_reoffer got wr=%0b id=%0d exp 1/2", a_wr, a_id);
    end
  endtask

  task automatic test_push_pop_same();
    step_a(0, 1, 9'd0);
    step_a(0, 1, 9'd1);
    step_a(1, 0, 0);
    checks++;
    if (a_st !== 2'b01 || a_cnt !== 10'd2) begin
      errors++; $display("FAIL pp_setup got st=%0d cnt=%0d exp 1/2", a_st, a_cnt);
    end
    step_a(0, 1, 9'd3);
    checks++;
    if (a_cnt !== 10'd2 || a_id !== 9'd0) begin
      errors++; $display("FAIL pp_same got cnt=%0d id=%0d exp 2/0", a_cnt, a_id);
    end
    step_a(1, 0, 0);
    step_a(0, 0, 0);
    step_a(1, 0, 0);
    step_a(0, 0, 0);
    checks++;
    if (a_wr !== 1'b1 || a_id !== 9'd3) begin
      errors++; $display("FAIL pp_order got wr=%0b id=%0d exp 1/3", a_wr, a_id);
    end
  endtask

  task automatic test_overflow();
    logic ovf_exp;
`ifdef BUFID_OVERFLOW_CHK_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    step_a(0, 1, 9'd0);
    step_a(0, 1, 9'd1);
    step_a(0, 1, 9'd2);
    step_a(0, 1, 9'd0);
    step_a(0, 1, 9'd1);
    checks++;
    if (a_ovf !== ovf_exp || a_cnt !== 10'd4) begin
      errors++;
      $display("FAIL ovf_pulse got ovf=%0b cnt=%0d exp %0b/4", a_ovf, a_cnt, ovf_exp);
    end
    step_a(0, 0, 0);
    checks++;
    if (a_ovf !== 1'b0 || a_cnt !== 10'd4) begin
      errors++; $display("FAIL ovf_once got ovf=%0b cnt=%0d exp 0/4", a_ovf, a_cnt);
    end
  endtask

  task automatic test_reset_mid_offer();
    for (int j = 0; j < 3; j++) begin
      b_ack = 1'b1;
      step_a(0, 0, 0);
      b_ack = 1'b0;
      step_a(0, 0, 0);
    end
    checks++;
    if (b_wr !== 1'b1 || b_id !== 9'd5) begin
      errors++; $display("FAIL mid_hold got wr=%0b id=%0d exp 1/5", b_wr, b_id);
    end
    rst = 1'b1;
    step_a(0, 0, 0);
    checks++;
    if (b_wr !== 1'b0 || b_id !== 9'd0 || b_cnt !== 10'd0 || b_st !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst got wr=%0b id=%0d cnt=%0d st=%0d exp 0/0/0/0",
               b_wr, b_id, b_cnt, b_st);
    end
    wait_b_init("reinit");
  endtask

  initial begin
    rst         = 1'b1;
    a_ack       = 1'b0;
    a_free_wr   = 1'b0;
    a_free      = '0;
    b_ack       = 1'b0;
    b_free_wr   = 1'b0;
    b_free      = '0;
    a_off       = 1'b0;
    a_cur       = '0;
    a_init_left = NA;
    test_reset();
    test_init();
    test_offer_order();
    test_drain_empty();
    test_push_pop_same();
    test_overflow();
    test_reset_mid_offer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_bufid_alloc.md
PKT_BUFID_ALLOC -- requirements
Module: pkt_bufid_alloc

Interface
REQ-001 SHALL have parameter: BUFID_NUM, 512, number of packet buffer IDs in the pool (legal 2..512; IDs are 0..BUFID_NUM-1).
REQ-002 SHALL have port: i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: o_pkt_bufid_wr  output  1  free buffer ID offered to the descriptor send stage.
REQ-005 SHALL have port: ov_pkt_bufid  output  9  offered buffer ID; valid while o_pkt_bufid_wr=1.
REQ-006 SHALL have port: i_pkt_bufid_ack  input  1  one-cycle pulse from the consumer; offered ID taken.
REQ-007 SHALL have port: i_bufid_free_wr  input  1  one-cycle pulse; a buffer ID is returned to the pool.
REQ-008 SHALL have port: iv_bufid_free  input  9  returned buffer ID; sampled when i_bufid_free_wr=1.
REQ-009 SHALL have port: ov_free_bufid_cnt  output  10  IDs held in the free list, excluding any ID currently offered.
REQ-010 SHALL have port: o_pool_empty  output  1  high when ov_free_bufid_cnt=0.
REQ-011 SHALL have port: o_free_overflow  output  1  one-cycle pulse on a discarded return (see Configuration).
REQ-012 SHALL have port: ov_alloc_state  output  2  FSM state for debug: init_s=2'b00, idle_s=2'b01, offer_s=2'b10.

Function
REQ-013 SHALL hold the free list as a circular FIFO of BUFID_NUM 9-bit entries with read/write pointers wrapping from BUFID_NUM-1 to 0.
REQ-014 SHALL in init_s write ID k to entry k, one per cycle, k=0..BUFID_NUM-1, keeping o_pkt_bufid_wr=0; after the last write, set ov_free_bufid_cnt=BUFID_NUM and enter idle_s.
REQ-015 SHALL in idle_s with count>0 pop the head entry onto ov_pkt_bufid, assert o_pkt_bufid_wr, decrement count, and enter offer_s on the same edge.
REQ-016 SHALL in idle_s with count=0 keep o_pkt_bufid_wr=0 and remain in idle_s.
REQ-017 SHALL in offer_s hold o_pkt_bufid_wr=1 and ov_pkt_bufid stable until i_pkt_bufid_ack=1 is sampled; on that edge, drive o_pkt_bufid_wr=0, ov_pkt_bufid=0, and enter idle_s.
REQ-018 SHALL ignore i_pkt_bufid_ack in init_s and idle_s.
REQ-019 SHALL therefore offer at most one ID per two cycles (offer edge, ack edge).
REQ-020 SHALL in idle_s and offer_s push iv_bufid_free at the tail on i_bufid_free_wr=1 when count<BUFID_NUM, incrementing count.
REQ-021 SHALL, when a pop and a push occur on the same edge, perform both and leave count unchanged; a push into an empty list is poppable no earlier than the following cycle.
REQ-022 SHALL discard i_bufid_free_wr during init_s.
REQ-023 SHALL discard a return when count=BUFID_NUM (list full, no pop on the same edge), leaving pointers and count unchanged.
REQ-024 SHALL drive o_pool_empty combinationally from count.

Reset
REQ-025 SHALL on i_rst=1 at any edge, including mid-init and mid-offer: o_pkt_bufid_wr=0, ov_pkt_bufid=0, ov_free_bufid_cnt=0, o_free_overflow=0, pointers=0, init counter=0, and state=init_s; every ID is free again after re-initialisation.
REQ-026 SHALL begin init_s writes on the first edge with i_rst=0.

Configuration
REQ-027 SHALL, with macro BUFID_OVERFLOW_CHK_EN defined, pulse o_free_overflow=1 for one cycle on each return discarded per REQ-023.
REQ-028 SHALL, without BUFID_OVERFLOW_CHK_EN, tie o_free_overflow to 0 and still discard per REQ-023.

Verification
REQ-029 SHALL cover: release reset, BUFID_NUM=512 -> wr=0 for 512 cycles, then wr=1 with ID 0 and count=511.
REQ-030 SHALL cover: ack every offer with a one-cycle pulse -> IDs 0,1,2 offered in order, wr=0 for one cycle between offers.
REQ-031 SHALL cover: BUFID_NUM=4, four acks -> o_pool_empty=1 and wr stays 0; return ID 2 -> ID 2 offered one cycle after the push.
REQ-032 SHALL cover: BUFID_NUM=4, count=2 in idle_s, return ID 3 on the pop edge -> count stays 2 and ID 3 is later offered in FIFO order.
REQ-033 SHALL cover: with BUFID_OVERFLOW_CHK_EN, count=4 of 4 during offer_s, return ID 1 -> o_free_overflow pulses once and count stays 4; without the macro -> o_free_overflow stays 0.
REQ-034 SHALL cover: i_rst=1 during offer_s holding ID 5 -> wr=0 next edge; after release, re-init and ID 0 offered first.
